// File: rtl/td4_pkg.sv
// Shared sizes and loader state encoding for the td4 core and its program loader.
package td4_pkg;

  localparam int TD4_ADDR_W  = 4;
  localparam int TD4_INSTR_W = 8;
  localparam int TD4_DEPTH   = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CKSUM = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } loader_state_t;

endpackage

// File: rtl/prog_mem.sv
// Instruction store: one synchronous write port, zero-latency combinational read, async clear.
// No flow control; a write issued on an edge is visible on rdata right after that edge.
module prog_mem #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 16
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader for the td4 CPU; combinational fetch, registered status/CPU reset.
// load_ready only in LOAD/CKSUM and never while load_start is high; gaps in load_valid just stall.
module prog_loader
  import td4_pkg::*;
#(
  parameter int ADDR_W  = TD4_ADDR_W,
  parameter int INSTR_W = TD4_INSTR_W,
  parameter int DEPTH   = TD4_DEPTH
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic [ADDR_W-1:0]  address,
  output logic [INSTR_W-1:0] instr,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [7:0]         load_data,
  output logic               load_ready,
  output logic               load_done,
  output logic               load_err,
  output logic               cpu_n_reset
);

  loader_state_t     state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [7:0]        sum, sum_nxt;
  logic [7:0]        cksum_total;
  logic              err_nxt, done_nxt;
  logic              xfer, mem_we;

  assign load_ready  = ((state == LOAD) || (state == CKSUM)) && !load_start;
  assign xfer        = load_valid && load_ready;
  assign cksum_total = sum + load_data;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sum         <= '0;
      load_err    <= 1'b0;
      load_done   <= 1'b0;
      cpu_n_reset <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      sum         <= sum_nxt;
      load_err    <= err_nxt;
      load_done   <= done_nxt;
      cpu_n_reset <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sum_nxt   = sum;
    err_nxt   = load_err;
    done_nxt  = 1'b0;
    mem_we    = 1'b0;
    if (load_start) begin
      // A restart wins over any byte offered in the same cycle (load_ready is low then).
      state_nxt = LOAD;
      cnt_nxt   = '0;
      sum_nxt   = '0;
      err_nxt   = 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (xfer) begin
            mem_we  = 1'b1;
            sum_nxt = sum + load_data;
            cnt_nxt = cnt + 1'b1;
            if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = CKSUM;
          end
        end
        CKSUM: begin
          if (xfer) begin
            if (cksum_total == 8'h00) begin
              state_nxt = RUN;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = ERR;
              err_nxt   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  prog_mem #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk    (clk),
    .n_reset(n_reset),
    .we     (mem_we),
    .waddr  (cnt),
    .wdata  (load_data),
    .raddr  (address),
    .rdata  (instr)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected image bytes queued as driven, popped when memory is read back.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       n_reset = 1'b1;
  logic [3:0] address = '0;
  logic [7:0] instr;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_ready, load_done, load_err, cpu_n_reset;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_seen = 0;
  logic [7:0] exp_q[$];

  prog_loader dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .address    (address),
    .instr      (instr),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_err   (load_err),
    .cpu_n_reset(cpu_n_reset)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (load_done) done_seen <= done_seen + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All stepping tasks start and end just after a falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_load(input logic vld);
    load_start = 1'b1;
    load_valid = vld;
    load_data  = 8'hAA;
    #1 chk("ready_low_on_start", load_ready, 0);
    step();
    load_start = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit push);
    load_valid = 1'b1;
    load_data  = d;
    #1 chk("ready_high_in_load", load_ready, 1);
    step();
    load_valid = 1'b0;
    if (push) exp_q.push_back(d);
  endtask

  task automatic verify_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      logic [7:0] e;
      address = 4'(a);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
      #1 chk(tag, instr, e);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_cpu_n_reset"}, cpu_n_reset, 0);
    chk({tag, "_load_ready"}, load_ready, 0);
    chk({tag, "_load_err"}, load_err, 0);
    for (int a = 0; a < 16; a++) exp_q.push_back(8'h00);
    verify_mem({tag, "_mem_zero"});
  endtask

  // Sends a 16-byte image plus checksum; returns edges from first transfer to checksum edge inclusive.
  task automatic send_image(input logic [7:0] img[16], input logic [7:0] ck,
                            input bit stall, output int span);
    int t0;
    t0 = 0;
    for (int i = 0; i < 16; i++) begin
      send_byte(img[i], 1'b1);
      if (i == 0) t0 = cyc;
      if (stall) step();
    end
    chk("cpu_held_before_cksum", cpu_n_reset, 0);
    send_byte(ck, 1'b0);
    span = cyc - t0 + 1;
  endtask

  logic [7:0] img_a[16];
  logic [7:0] img_b[16];
  logic [7:0] sum_b;
  int span;
  int done_before;

  initial begin
    for (int i = 0; i < 16; i++) img_a[i] = 8'(i + 1);
    sum_b = 8'h00;
    for (int i = 0; i < 16; i++) begin
      img_b[i] = 8'(8'hF0 - 8'(i * 3));
      sum_b = sum_b + img_b[i];
    end

    // Reset asserted mid-cycle
    @(negedge clk);
    #2 n_reset = 1'b0;
    #1 check_reset_state("reset");
    n_reset = 1'b1;
    step();
    chk("idle_ready_low", load_ready, 0);

    // Good load, back-to-back
    done_before = done_seen;
    start_load(1'b0);
    chk("start_cpu_held", cpu_n_reset, 0);
    send_image(img_a, 8'h78, 1'b0, span);
    chk("good_cpu_released", cpu_n_reset, 1);
    chk("good_done_pulse", load_done, 1);
    chk("good_err_low", load_err, 0);
    chk("good_span", span, 17);
    load_valid = 1'b1;
    #1 chk("run_ready_low", load_ready, 0);
    step();
    load_valid = 1'b0;
    chk("good_done_one_cycle", load_done, 0);
    chk("good_done_count", done_seen - done_before, 1);
    chk("run_cpu_stays", cpu_n_reset, 1);
    address = 4'd5;
    #1 chk("good_addr5", instr, 8'h06);
    verify_mem("good_mem");

    // Restart while in RUN, then bad checksum
    start_load(1'b0);
    chk("restart_run_cpu_drop", cpu_n_reset, 0);
    done_before = done_seen;
    send_image(img_a, 8'h77, 1'b0, span);
    chk("bad_err_set", load_err, 1);
    chk("bad_cpu_held", cpu_n_reset, 0);
    step();
    chk("bad_ready_low", load_ready, 0);
    chk("bad_err_sticky", load_err, 1);
    chk("bad_no_done", done_seen - done_before, 0);
    verify_mem("bad_mem_kept");
    start_load(1'b0);
    chk("start_clears_err", load_err, 0);

    // Restart mid-load with a byte offered on the same cycle
    for (int i = 0; i < 7; i++) send_byte(8'h55 + 8'(i), 1'b0);
    start_load(1'b1);
    done_before = done_seen;
    send_image(img_b, 8'(8'h00 - sum_b), 1'b0, span);
    chk("restart_cpu_released", cpu_n_reset, 1);
    chk("restart_done", load_done, 1);
    step();
    chk("restart_done_count", done_seen - done_before, 1);
    verify_mem("restart_mem");

    // Stalled stream: valid toggles every cycle
    start_load(1'b0);
    done_before = done_seen;
    send_image(img_a, 8'h78, 1'b1, span);
    chk("stall_done", load_done, 1);
    chk("stall_cpu_released", cpu_n_reset, 1);
    chk("stall_span", span, 33);
    step();
    chk("stall_done_count", done_seen - done_before, 1);
    verify_mem("stall_mem");

    // Async reset after 10 bytes
    start_load(1'b0);
    done_before = done_seen;
    for (int i = 0; i < 10; i++) send_byte(8'hC0 + 8'(i), 1'b0);
    #2 n_reset = 1'b0;
    #1 check_reset_state("midload_reset");
    n_reset = 1'b1;
    load_valid = 1'b1;
    #1 chk("post_reset_idle_ready", load_ready, 0);
    step();
    step();
    load_valid = 1'b0;
    chk("post_reset_no_done", done_seen - done_before, 0);
    chk("post_reset_cpu_held", cpu_n_reset, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
